alu: RTL and testbench
======================

// Module: alu
// PURPOSE
//   Registered combinational-style ALU: two WIDTH-bit unsigned operands, 3-bit opcode, 2*WIDTH-bit result.
//   Sits in the datapath after operand registers.
//   Result and valid are captured one clock after i_valid.
//   Result width of 2*WIDTH holds the full product and sign-extended differences.
// PARAMETERS
//   WIDTH   4   operand width in bits (>=2); result is 2*WIDTH bits
// PORTS
//   i_clk     in   1         clock, all state on rising edge
//   i_rst_n   in   1         synchronous active-low reset
//   i_valid   in   1         operands/opcode valid this cycle
//   i_inA     in   WIDTH     operand A, unsigned
//   i_inB     in   WIDTH     operand B, unsigned
//   i_s       in   3         opcode
//   o_ALU     out  2*WIDTH   result, registered
//   o_valid   out  1         o_ALU updated this cycle
// BEHAVIOUR
//   - One clock; reset is synchronous and active-low.
//   - While i_rst_n==0 at a rising edge: o_ALU<=0, o_valid<=0. Reset overrides a simultaneous i_valid.
//   - Latency 1: at edge with i_valid=1, o_ALU<=f(i_s,A,B) and o_valid<=1.
//   - With i_valid=0: o_valid<=0 and o_ALU holds its previous value.
//   - No back-pressure; a new op is accepted every cycle.
//   - Opcodes (A,B zero-extended to 2*WIDTH before the op):
//     000 MUL  A*B, full 2*WIDTH-bit product, never overflows
//     001 ADD  A+B, carry lands in bit WIDTH
//     010 SUB  A-B, two's complement at 2*WIDTH bits (A<B -> negative, e.g. 10-15 = 8'hFB)
//     011 SHL  A<<B at 2*WIDTH bits; bits shifted past MSB are lost; B>=2*WIDTH -> 0
//     100 SHR  A>>B logical; B>=WIDTH -> 0
//     101 CMP  {0..., A>B, A==B, A<B} in bits [2:0]; exactly one bit set
//     110,111  see CONFIGURATION
//   - Bits not defined by an op are 0.
//   - Output is a pure function of the inputs sampled at that edge; no history.
// CONFIGURATION
//   ALU_BITWISE_EN defined:
//     110 = A AND B, zero-extended
//     111 = A XOR B, zero-extended
//   ALU_BITWISE_EN undefined:
//     110/111 produce o_ALU=0 with o_valid=1 (accepted, illegal op).
// TESTING (WIDTH=4)
//   - Reset: hold i_rst_n=0 with i_valid=1 -> o_ALU=0 and o_valid=0 after the edge. Release reset -> normal ops resume.
//   - A=15, B=10, sweep i_s 000..101 with one op per cycle -> o_ALU = 150, 25, 5, 0, 0, 4.
//     Each result appears exactly 1 cycle after its op is issued.
//   - A=10, B=15, SUB -> 8'hFB; CMP -> 1.
//   - A=15, B=2: SHL -> 60, SHR -> 3. A=9, B=9: CMP -> 2.
//   - Valid gating: i_valid=0 for 3 cycles after ADD(15,10) -> o_valid=0, o_ALU holds 25.
//   - Bitwise: A=12, B=10, i_s=110/111 -> 8 / 6 with ALU_BITWISE_EN; 0 / 0 without.

Source files
------------

// File: rtl/alu_if.sv
// ALU operand/result bundle. The master drives the operands and opcode.
// The slave, which is the ALU, returns the registered result and its valid flag.
interface alu_if #(
  parameter int WIDTH = 4
) ();
  logic                 i_valid;
  logic [WIDTH-1:0]     i_inA;
  logic [WIDTH-1:0]     i_inB;
  logic [2:0]           i_s;
  logic [2*WIDTH-1:0]   o_ALU;
  logic                 o_valid;

  modport master (
    output i_valid, i_inA, i_inB, i_s,
    input  o_ALU, o_valid
  );

  modport slave (
    input  i_valid, i_inA, i_inB, i_s,
    output o_ALU, o_valid
  );
endinterface

// File: rtl/alu.sv
// Registered ALU. It takes two unsigned WIDTH-bit operands and produces a 2*WIDTH-bit result.
// The result appears one clock after i_valid.
// Optional macro ALU_BITWISE_EN enables the AND (110) and XOR (111) opcodes.
// Without that macro, opcodes 110 and 111 are accepted and return 0.
module alu #(
  parameter int WIDTH = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  alu_if.slave bus
);

  localparam int RW = 2 * WIDTH;

  typedef enum logic [2:0] {
    OP_MUL = 3'b000,
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_SHL = 3'b011,
    OP_SHR = 3'b100,
    OP_CMP = 3'b101,
    OP_AND = 3'b110,
    OP_XOR = 3'b111
  } op_e;

  logic [RW-1:0] a_ext;
  logic [RW-1:0] b_ext;
  logic [RW-1:0] alu_d, alu_q;
  logic          valid_q;

  assign a_ext = {{WIDTH{1'b0}}, bus.i_inA};
  assign b_ext = {{WIDTH{1'b0}}, bus.i_inB};

  // Result selection. Shifting by B past the result width yields 0 naturally.
  always_comb begin
    alu_d = '0;
    case (op_e'(bus.i_s))
      OP_MUL: alu_d = a_ext * b_ext;
      OP_ADD: alu_d = a_ext + b_ext;
      OP_SUB: alu_d = a_ext - b_ext;
      OP_SHL: alu_d = a_ext << bus.i_inB;
      OP_SHR: alu_d = a_ext >> bus.i_inB;
      OP_CMP: alu_d = {{(RW-3){1'b0}},
                       (bus.i_inA > bus.i_inB),
                       (bus.i_inA == bus.i_inB),
                       (bus.i_inA < bus.i_inB)};
`ifdef ALU_BITWISE_EN
      OP_AND: alu_d = a_ext & b_ext;
      OP_XOR: alu_d = a_ext ^ b_ext;
`else
      OP_AND: alu_d = '0;
      OP_XOR: alu_d = '0;
`endif
      default: alu_d = '0;
    endcase
  end

  // Output register. The result updates only on an accepted op; valid pulses once per op.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      alu_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.i_valid;
      if (bus.i_valid) alu_q <= alu_d;
    end
  end

  assign bus.o_ALU   = alu_q;
  assign bus.o_valid = valid_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu at WIDTH=4.
// The bench runs directed cases first, then randomized ops checked against an arithmetic model.
module tb_alu;

  localparam int W  = 4;
  localparam int RW = 2 * W;

  logic i_clk;
  logic i_rst_n;

  alu_if #(.WIDTH(W)) bus ();

  alu #(.WIDTH(W)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [RW-1:0] exp_alu;
  logic          exp_valid;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // The model works on plain integers, with results taken modulo 2^(2W).
  function automatic logic [RW-1:0] ref_alu(input int op, input int a, input int b);
    int m;
    int r;
    m = 1 << RW;
    case (op)
      0: r = a * b;
      1: r = a + b;
      2: r = (a - b + m) % m;
      3: r = (b >= RW) ? 0 : (a * (1 << b)) % m;
      4: r = a / (1 << b);
      5: r = (a > b) ? 4 : ((a == b) ? 2 : 1);
`ifdef ALU_BITWISE_EN
      6: r = a & b;
      7: r = a ^ b;
`else
      6: r = 0;
      7: r = 0;
`endif
      default: r = 0;
    endcase
    return r[RW-1:0];
  endfunction

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drives one cycle of inputs, waits for the edge, and samples 1 time unit later.
  task automatic step(input logic v, input int op, input int a, input int b);
    bus.i_valid = v;
    bus.i_s     = op[2:0];
    bus.i_inA   = a[W-1:0];
    bus.i_inB   = b[W-1:0];
    @(posedge i_clk);
    #1;
  endtask

  task automatic op_check(input string tag, input int op, input int a, input int b,
                          input logic [RW-1:0] expv);
    step(1'b1, op, a, b);
    check({tag, "_val"}, bus.o_ALU, expv);
    check({tag, "_vld"}, {{(RW-1){1'b0}}, bus.o_valid}, {{(RW-1){1'b0}}, 1'b1});
  endtask

  initial begin
    int op, a, b;
    logic v;
    logic [RW-1:0] held;

    // Reset overrides a simultaneous valid op.
    i_rst_n = 1'b0;
    step(1'b1, 0, 15, 15);
    check("rst_alu", bus.o_ALU, '0);
    check("rst_vld", {{(RW-1){1'b0}}, bus.o_valid}, '0);
    step(1'b1, 1, 7, 7);
    check("rst2_alu", bus.o_ALU, '0);
    i_rst_n = 1'b1;

    // Back-to-back sweep: each result lands exactly one edge after issue.
    op_check("mul_15_10", 0, 15, 10, 8'd150);
    op_check("add_15_10", 1, 15, 10, 8'd25);
    op_check("sub_15_10", 2, 15, 10, 8'd5);
    op_check("shl_15_10", 3, 15, 10, 8'd0);
    op_check("shr_15_10", 4, 15, 10, 8'd0);
    op_check("cmp_15_10", 5, 15, 10, 8'd4);

    op_check("sub_10_15", 2, 10, 15, 8'hFB);
    op_check("cmp_10_15", 5, 10, 15, 8'd1);
    op_check("shl_15_2",  3, 15, 2,  8'd60);
    op_check("shr_15_2",  4, 15, 2,  8'd3);
    op_check("cmp_9_9",   5, 9,  9,  8'd2);
    op_check("mul_max",   0, 15, 15, 8'd225);
    op_check("shl_15_7",  3, 15, 7,  8'h80);
    op_check("shr_15_3",  4, 15, 3,  8'd1);

    // With valid low, the result holds and valid drops.
    op_check("add_hold", 1, 15, 10, 8'd25);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 0, 3, 5);
      check("hold_alu", bus.o_ALU, 8'd25);
      check("hold_vld", {{(RW-1){1'b0}}, bus.o_valid}, '0);
    end

`ifdef ALU_BITWISE_EN
    op_check("and_12_10", 6, 12, 10, 8'd8);
    op_check("xor_12_10", 7, 12, 10, 8'd6);
`else
    op_check("and_12_10", 6, 12, 10, 8'd0);
    op_check("xor_12_10", 7, 12, 10, 8'd0);
`endif

    // Randomized traffic with occasional idle cycles and resets.
    held = bus.o_ALU;
    for (int i = 0; i < 300; i++) begin
      op = int'($urandom_range(0, 7));
      a  = int'($urandom_range(0, 15));
      b  = int'($urandom_range(0, 15));
      v  = ($urandom_range(0, 3) != 0);
      i_rst_n = ($urandom_range(0, 39) != 0);
      if (!i_rst_n) begin
        exp_alu = '0;
        exp_valid = 1'b0;
      end else if (v) begin
        exp_alu = ref_alu(op, a, b);
        exp_valid = 1'b1;
      end else begin
        exp_alu = held;
        exp_valid = 1'b0;
      end
      step(v, op, a, b);
      check("rnd_alu", bus.o_ALU, exp_alu);
      check("rnd_vld", {{(RW-1){1'b0}}, bus.o_valid}, {{(RW-1){1'b0}}, exp_valid});
      held = exp_alu;
    end
    i_rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
